tj_trigger_detect: RTL and testbench

Plaintext-sequence trigger stage for the AES_T400 benchmark. Monitors every plaintext loaded into the AES core and, after a programmed sequence of four specific plaintexts arrives on consecutive load strobes, raises `Tj_Trig` for a fixed pulse width while presenting a key snapshot. Sits directly upstream of the AM leakage transmitter and drives that block's `Tj_Trig` and `key` inputs.

---
 rtl/tj_trigger_detect.sv | 84 ++++++++
 tb/tb_tj_trigger_detect.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tj_trigger_detect.sv
// Plaintext-sequence trigger: fires Tj_Trig for TRIG_CYCLES clocks after P0,P1,P2,P3 arrive on consecutive loads.
// Define TJ_TRIG_REARM_EN to re-arm after each fire; default build locks until reset.
module tj_trigger_detect #(
  parameter logic [127:0] P0          = 128'h3243f6a8885a308d313198a2e0370734,
  parameter logic [127:0] P1          = 128'h00112233445566778899aabbccddeeff,
  parameter logic [127:0] P2          = 128'h00000000000000000000000000000000,
  parameter logic [127:0] P3          = 128'hffffffffffffffffffffffffffffffff,
  parameter int           TRIG_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] state,
  input  logic [127:0] key,
  output logic         Tj_Trig,
  output logic [127:0] key_out,
  output logic         armed
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M1   = 3'd1,
    M2   = 3'd2,
    M3   = 3'd3,
    FIRE = 3'd4,
    LOCK = 3'd5
  } fsm_t;

  localparam logic [7:0] TRIG_LOAD = 8'(TRIG_CYCLES - 1);

`ifdef TJ_TRIG_REARM_EN
  localparam fsm_t FIRE_EXIT = IDLE;
`else
  localparam fsm_t FIRE_EXIT = LOCK;
`endif

  fsm_t       fsm_cur;
  fsm_t       fsm_nxt;
  logic [7:0] trig_cnt;
  logic       trig_q;
  logic       fire_entry;

  // A mismatch restarts at M1 when the offending word is itself P0.
  function automatic fsm_t restart(input logic [127:0] pt);
    return (pt == P0) ? M1 : IDLE;
  endfunction

  always_comb begin
    fsm_nxt = fsm_cur;
    unique case (fsm_cur)
      IDLE: if (load && (state == P0)) fsm_nxt = M1;
      M1:   if (load) fsm_nxt = (state == P1) ? M2   : restart(state);
      M2:   if (load) fsm_nxt = (state == P2) ? M3   : restart(state);
      M3:   if (load) fsm_nxt = (state == P3) ? FIRE : restart(state);
      FIRE: if (trig_cnt == 8'd0) fsm_nxt = FIRE_EXIT;
      LOCK: fsm_nxt = LOCK;
      default: fsm_nxt = IDLE;
    endcase
  end

  assign fire_entry = (fsm_cur == M3) && (fsm_nxt == FIRE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_cur  <= IDLE;
      trig_cnt <= 8'd0;
      trig_q   <= 1'b0;
      key_out  <= '0;
    end else begin
      fsm_cur <= fsm_nxt;
      trig_q  <= (fsm_nxt == FIRE);
      if (fire_entry) begin
        key_out  <= key;
        trig_cnt <= TRIG_LOAD;
      end else if ((fsm_cur == FIRE) && (trig_cnt != 8'd0)) begin
        trig_cnt <= trig_cnt - 8'd1;
      end
    end
  end

  assign Tj_Trig = trig_q;
  assign armed   = (fsm_cur != FIRE) && (fsm_cur != LOCK);

endmodule

// File: tb/tb_tj_trigger_detect.sv
// Directed bench for tj_trigger_detect: default-width DUT plus a TRIG_CYCLES=1 instance on shared stimulus.
module tb_tj_trigger_detect;

  localparam logic [127:0] P0 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] P2 = 128'h00000000000000000000000000000000;
  localparam logic [127:0] P3 = 128'hffffffffffffffffffffffffffffffff;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K3 = 128'hdeadbeefcafebabe0123456789abcdef;
  localparam logic [127:0] K4 = 128'h55aa55aa0f0f0f0ff0f0f0f0a5a5a5a5;
`ifdef TJ_TRIG_REARM_EN
  localparam logic REARM = 1'b1;
`else
  localparam logic REARM = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         load;
  logic [127:0] state;
  logic [127:0] key;
  logic         Tj_Trig,  Tj_Trig2;
  logic [127:0] key_out,  key_out2;
  logic         armed,    armed2;

  int checks = 0;
  int errors = 0;
  int hi;

  tj_trigger_detect dut (
    .clk(clk), .rst(rst), .load(load), .state(state), .key(key),
    .Tj_Trig(Tj_Trig), .key_out(key_out), .armed(armed)
  );

  tj_trigger_detect #(.TRIG_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .state(state), .key(key),
    .Tj_Trig(Tj_Trig2), .key_out(key_out2), .armed(armed2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, return 1 ns after the following rising edge.
  task automatic cyc(input logic ld, input logic [127:0] v);
    @(negedge clk);
    load  = ld;
    state = v;
    @(posedge clk);
    #1;
  endtask

  task automatic run_idle(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, '0);
      cnt += int'(Tj_Trig);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic send_seq();
    cyc(1'b1, P0);
    cyc(1'b1, P1);
    cyc(1'b1, P2);
    cyc(1'b1, P3);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; state = '0; key = '0;
    #1 rst = 1'b0;
    #2;
    chk("rst_trig",  128'(Tj_Trig), 128'(1'b0));
    chk("rst_key",   key_out,       '0);
    chk("rst_armed", 128'(armed),   128'(1'b1));
    chk("rst_trig2", 128'(Tj_Trig2), 128'(1'b0));
    @(negedge clk);
    rst = 1'b1;

    // Basic sequence; a P0 load during FIRE must be ignored.
    key = K1;
    cyc(1'b1, P0);
    chk("t1_armed_m1", 128'(armed), 128'(1'b1));
    cyc(1'b1, P1);
    cyc(1'b1, P2);
    chk("t1_trig_pre", 128'(Tj_Trig), 128'(1'b0));
    cyc(1'b1, P3);
    chk("t1_trig_1st", 128'(Tj_Trig), 128'(1'b1));
    chk("t1_key",      key_out,       K1);
    chk("t1_armed",    128'(armed),   128'(1'b0));
    chk("t1_trig2",    128'(Tj_Trig2), 128'(1'b1));
    chk("t1_key2",     key_out2,      K1);
    cyc(1'b1, P0);
    chk("t1_trig_2nd",  128'(Tj_Trig),  128'(1'b1));
    chk("t1_trig2_off", 128'(Tj_Trig2), 128'(1'b0));
    chk("t1_armed2",    128'(armed2),   128'(REARM));
    run_idle(2, hi);
    chk("t1_pulse_tail", 128'(hi), 128'(2));
    cyc(1'b0, '0);
    chk("t1_trig_end",  128'(Tj_Trig), 128'(1'b0));
    chk("t1_armed_end", 128'(armed),   128'(REARM));

    // Overlap restart through the P0 mismatch path.
    do_reset();
    key = K2;
    cyc(1'b1, P0); cyc(1'b1, P1); cyc(1'b1, P0); cyc(1'b1, P1); cyc(1'b1, P2);
    chk("t2_trig_pre", 128'(Tj_Trig), 128'(1'b0));
    cyc(1'b1, P3);
    chk("t2_trig", 128'(Tj_Trig), 128'(1'b1));
    chk("t2_key",  key_out,       K2);
    run_idle(6, hi);
    chk("t2_pulse_tail", 128'(hi), 128'(3));

    // Broken sequence must not fire.
    do_reset();
    cyc(1'b1, P0); cyc(1'b1, P1); cyc(1'b1, 128'h1234); cyc(1'b1, P2); cyc(1'b1, P3);
    chk("t3_trig", 128'(Tj_Trig), 128'(1'b0));
    run_idle(5, hi);
    chk("t3_hi",    128'(hi),    128'(0));
    chk("t3_armed", 128'(armed), 128'(1'b1));
    chk("t3_key",   key_out,     '0);

    // Idle gaps between loads keep progress.
    key = K3;
    cyc(1'b1, P0);
    run_idle(3, hi);
    cyc(1'b1, P1);
    run_idle(5, hi);
    cyc(1'b1, P2);
    cyc(1'b1, P3);
    chk("t4_trig", 128'(Tj_Trig), 128'(1'b1));
    chk("t4_key",  key_out,       K3);
    run_idle(6, hi);
    chk("t4_pulse_tail", 128'(hi),    128'(3));
    chk("t4_armed",      128'(armed), 128'(REARM));

    // Second complete sequence: one-shot ignores it, re-arm fires again.
    key = K4;
    send_seq();
    chk("t5_trig",  128'(Tj_Trig), 128'(REARM));
    chk("t5_key",   key_out,       REARM ? K4 : K3);
    chk("t5_armed", 128'(armed),   128'(1'b0));
    run_idle(6, hi);
    chk("t5_pulse_tail", 128'(hi), REARM ? 128'(3) : 128'(0));

    // Asynchronous reset in the second FIRE cycle.
    do_reset();
    key = K1;
    send_seq();
    cyc(1'b0, '0);
    chk("t6_trig_mid", 128'(Tj_Trig), 128'(1'b1));
    #2 rst = 1'b0;
    #1;
    chk("t6_trig_async",  128'(Tj_Trig), 128'(1'b0));
    chk("t6_key_async",   key_out,       '0);
    chk("t6_armed_async", 128'(armed),   128'(1'b1));
    @(negedge clk);
    rst = 1'b1;
    run_idle(3, hi);
    chk("t6_no_residual", 128'(hi), 128'(0));
    key = K2;
    send_seq();
    chk("t6_refire",     128'(Tj_Trig), 128'(1'b1));
    chk("t6_refire_key", key_out,       K2);
    run_idle(6, hi);
    chk("t6_refire_tail", 128'(hi), 128'(3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
